// File: rtl/spi_command_decoder.sv
// SPI command decoder: turns bytes from the SPI driver into capture and
// readout control. It also produces the reply byte for the next transfer.
module spi_command_decoder #(
    parameter logic [7:0] ACK_BYTE = 8'hA5,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [7:0] command_byte,
    input  logic       cmd_valid,
    input  logic       capture_busy,
    output logic [7:0] response_byte,
    output logic       data_transfer,
    output logic       capture_start,
    output logic       readout_done,
    output logic [1:0] state_dbg
);

    localparam logic [7:0] CMD_NOP           = 8'h00;
    localparam logic [7:0] CMD_STATUS        = 8'h01;
    localparam logic [7:0] CMD_START_CAPTURE = 8'h10;
    localparam logic [7:0] CMD_START_READOUT = 8'h20;
    localparam logic [7:0] CMD_STOP_READOUT  = 8'h30;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEN_HI  = 2'd1,
        LEN_LO  = 2'd2,
        READOUT = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] word_count;
    logic [16:0] byte_remaining;
    logic [16:0] len_bytes;

    // A readout carries two bytes per word. The multiply by 2 is done as a
    // shift. The 17-bit result holds 2 x 16'hFFFF without overflow.
    assign len_bytes = {word_count[15:8], command_byte, 1'b0};
    assign state_dbg = state;

    // Command FSM. All outputs are registered, and state changes only on cmd_valid.
    // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge values.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            response_byte  <= 8'h00;
            data_transfer  <= 1'b0;
            capture_start  <= 1'b0;
            readout_done   <= 1'b0;
            word_count     <= 16'h0000;
            byte_remaining <= 17'd0;
        end else begin
            capture_start <= 1'b0;
            readout_done  <= 1'b0;
            if (cmd_valid) begin
                case (state)
                    IDLE: begin
                        case (command_byte)
                            CMD_NOP:    response_byte <= 8'h00;
                            CMD_STATUS: response_byte <= {6'b0, data_transfer, capture_busy};
                            CMD_START_CAPTURE: begin
                                if (capture_busy) begin
                                    response_byte <= ERR_BYTE;
                                end else begin
                                    capture_start <= 1'b1;
                                    response_byte <= ACK_BYTE;
                                end
                            end
                            CMD_START_READOUT: begin
                                response_byte <= ACK_BYTE;
                                state         <= LEN_HI;
                            end
                            default:    response_byte <= ERR_BYTE;
                        endcase
                    end
                    LEN_HI: begin
                        word_count[15:8] <= command_byte;
                        response_byte    <= 8'h00;
                        state            <= LEN_LO;
                    end
                    LEN_LO: begin
                        word_count[7:0] <= command_byte;
                        byte_remaining  <= len_bytes;
                        if (len_bytes != 17'd0) begin
                            data_transfer <= 1'b1;
                            response_byte <= ACK_BYTE;
                            state         <= READOUT;
                        end else begin
                            response_byte <= ERR_BYTE;
                            state         <= IDLE;
                        end
                    end
                    READOUT: begin
                        if (command_byte == CMD_STOP_READOUT) begin
                            byte_remaining <= 17'd0;
                            data_transfer  <= 1'b0;
                            readout_done   <= 1'b1;
                            response_byte  <= ACK_BYTE;
                            state          <= IDLE;
                        end else begin
                            // Every other byte, including start commands, is padding.
                            byte_remaining <= byte_remaining - 17'd1;
                            response_byte  <= 8'h00;
                            if (byte_remaining == 17'd1) begin
                                data_transfer <= 1'b0;
                                readout_done  <= 1'b1;
                                state         <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // The count reaches zero on the same edge that leaves READOUT, so a
    // padding byte never arrives while the count is already zero.
    a_no_wrap: assert property (@(posedge sys_clk) disable iff (!reset)
        (state == READOUT && cmd_valid && command_byte != CMD_STOP_READOUT)
        |-> byte_remaining != 17'd0);

    // The count starts at twice the programmed word count and only goes down.
    a_bounded: assert property (@(posedge sys_clk) disable iff (!reset)
        (state == READOUT) |-> byte_remaining <= {word_count, 1'b0});

endmodule

// File: tb/tb_spi_command_decoder.sv
// Self-checking bench for spi_command_decoder: a transaction-level model
// compared every cycle, plus directed sequences with literal expectations.
module tb_spi_command_decoder;

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] ERR = 8'hEE;

    logic       sys_clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] command_byte = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       capture_busy = 1'b0;
    logic [7:0] response_byte;
    logic       data_transfer;
    logic       capture_start;
    logic       readout_done;
    logic [1:0] state_dbg;

    int total = 0;
    int bad = 0;

    spi_command_decoder #(.ACK_BYTE(ACK), .ERR_BYTE(ERR)) dut (
        .sys_clk(sys_clk),
        .reset(reset),
        .command_byte(command_byte),
        .cmd_valid(cmd_valid),
        .capture_busy(capture_busy),
        .response_byte(response_byte),
        .data_transfer(data_transfer),
        .capture_start(capture_start),
        .readout_done(readout_done),
        .state_dbg(state_dbg)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: the number of length bytes still owed and the number of
    // readout bytes still owed. The reply register is tracked separately.
    int         m_len_needed = 0;
    int         m_len_acc = 0;
    int         m_remaining = 0;
    logic [7:0] m_resp = 8'h00;
    logic       m_dt = 1'b0;
    logic       m_cs = 1'b0;
    logic       m_rd = 1'b0;

    function automatic logic [1:0] m_state();
        if (m_remaining > 0) return 2'd3;
        if (m_len_needed == 2) return 2'd1;
        if (m_len_needed == 1) return 2'd2;
        return 2'd0;
    endfunction

    always @(negedge reset) begin
        m_len_needed = 0; m_len_acc = 0; m_remaining = 0;
        m_resp = 8'h00; m_dt = 1'b0; m_cs = 1'b0; m_rd = 1'b0;
    end

    always @(posedge sys_clk) begin
        if (reset) begin
            m_cs = 1'b0;
            m_rd = 1'b0;
            if (cmd_valid) begin
                if (m_remaining > 0) begin
                    if (command_byte == 8'h30) begin
                        m_remaining = 0; m_dt = 1'b0; m_rd = 1'b1; m_resp = ACK;
                    end else begin
                        m_remaining = m_remaining - 1;
                        m_resp = 8'h00;
                        if (m_remaining == 0) begin m_dt = 1'b0; m_rd = 1'b1; end
                    end
                end else if (m_len_needed > 0) begin
                    m_len_acc = m_len_acc * 256 + int'(command_byte);
                    m_len_needed = m_len_needed - 1;
                    if (m_len_needed == 0) begin
                        m_remaining = 2 * m_len_acc;
                        if (m_remaining > 0) begin m_dt = 1'b1; m_resp = ACK; end
                        else m_resp = ERR;
                    end else begin
                        m_resp = 8'h00;
                    end
                end else begin
                    case (command_byte)
                        8'h00: m_resp = 8'h00;
                        8'h01: m_resp = {6'b0, m_dt, capture_busy};
                        8'h10: begin
                            if (capture_busy) m_resp = ERR;
                            else begin m_resp = ACK; m_cs = 1'b1; end
                        end
                        8'h20: begin m_resp = ACK; m_len_needed = 2; m_len_acc = 0; end
                        default: m_resp = ERR;
                    endcase
                end
            end
        end
    end

    // Compare the outputs against the model on every falling edge.
    always @(negedge sys_clk) begin
        check("cmp_response", {24'h0, response_byte}, {24'h0, m_resp});
        check("cmp_data_transfer", {31'h0, data_transfer}, {31'h0, m_dt});
        check("cmp_capture_start", {31'h0, capture_start}, {31'h0, m_cs});
        check("cmp_readout_done", {31'h0, readout_done}, {31'h0, m_rd});
        check("cmp_state", {30'h0, state_dbg}, {30'h0, m_state()});
    end

    task automatic drive(input logic v, input logic [7:0] b);
        @(negedge sys_clk);
        cmd_valid = v;
        command_byte = b;
    endtask

    // Send one byte and return at the falling edge after it has been processed.
    task automatic cmd(input logic [7:0] b);
        drive(1'b1, b);
        drive(1'b0, 8'h00);
    endtask

    function automatic logic [7:0] pick_byte();
        logic [7:0] r;
        r = 8'($urandom);
        if (m_len_needed == 2) return ($urandom_range(0, 15) == 0) ? 8'h01 : 8'h00;
        if (m_len_needed == 1) return 8'($urandom_range(0, 12));
        if (m_remaining > 0) begin
            case ($urandom_range(0, 24))
                0: return 8'h30;
                1: return 8'h10;
                2: return 8'h20;
                3: return r;
                default: return 8'h00;
            endcase
        end
        case ($urandom_range(0, 6))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h10;
            3, 4: return 8'h20;
            5: return 8'h30;
            default: return r;
        endcase
    endfunction

    initial begin
        #12;
        check("reset_response", {24'h0, response_byte}, 32'h0);
        check("reset_data_transfer", {31'h0, data_transfer}, 32'h0);
        check("reset_state", {30'h0, state_dbg}, 32'h0);
        #11 reset = 1'b1;

        // Status with the capture module busy.
        capture_busy = 1'b1;
        cmd(8'h01);
        check("status_busy", {24'h0, response_byte}, 32'h01);
        check("status_dt", {31'h0, data_transfer}, 32'h0);

        // Capture start, then the same command refused while busy.
        capture_busy = 1'b0;
        cmd(8'h10);
        check("capture_pulse", {31'h0, capture_start}, 32'h1);
        check("capture_ack", {24'h0, response_byte}, 32'hA5);
        @(negedge sys_clk);
        check("capture_pulse_end", {31'h0, capture_start}, 32'h0);
        capture_busy = 1'b1;
        cmd(8'h10);
        check("capture_busy_nopulse", {31'h0, capture_start}, 32'h0);
        check("capture_busy_err", {24'h0, response_byte}, 32'hEE);
        capture_busy = 1'b0;

        // Unknown code is rejected.
        cmd(8'h7B);
        check("unknown_err", {24'h0, response_byte}, 32'hEE);

        // Full readout of 3 words: the length bytes are sent back to back.
        drive(1'b1, 8'h20);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h03);
        drive(1'b0, 8'h00);
        check("readout_dt_rise", {31'h0, data_transfer}, 32'h1);
        check("readout_ack", {24'h0, response_byte}, 32'hA5);
        check("readout_state", {30'h0, state_dbg}, 32'h3);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h00);
        drive(1'b0, 8'h00);
        check("readout_dt_before_last", {31'h0, data_transfer}, 32'h1);
        cmd(8'h00);
        check("readout_dt_fall", {31'h0, data_transfer}, 32'h0);
        check("readout_done_pulse", {31'h0, readout_done}, 32'h1);
        check("readout_idle", {30'h0, state_dbg}, 32'h0);
        @(negedge sys_clk);
        check("readout_done_end", {31'h0, readout_done}, 32'h0);

        // Abort a 256-word readout after 10 padding bytes.
        cmd(8'h20); cmd(8'h01); cmd(8'h00);
        for (int i = 0; i < 10; i++) cmd(8'h00);
        cmd(8'h30);
        check("abort_dt", {31'h0, data_transfer}, 32'h0);
        check("abort_done", {31'h0, readout_done}, 32'h1);
        check("abort_ack", {24'h0, response_byte}, 32'hA5);

        // Zero length is rejected.
        cmd(8'h20); cmd(8'h00); cmd(8'h00);
        check("zero_err", {24'h0, response_byte}, 32'hEE);
        check("zero_dt", {31'h0, data_transfer}, 32'h0);
        check("zero_state", {30'h0, state_dbg}, 32'h0);

        // Largest word count, then abort.
        cmd(8'h20); cmd(8'hFF); cmd(8'hFF);
        check("max_len_count", {15'h0, dut.byte_remaining}, 32'h1FFFE);
        check("max_len_dt", {31'h0, data_transfer}, 32'h1);
        cmd(8'h10); cmd(8'h20);
        check("max_len_padding", {15'h0, dut.byte_remaining}, 32'h1FFFC);
        check("max_len_no_capture", {31'h0, capture_start}, 32'h0);
        cmd(8'h30);

        // Reset asserted mid-readout, away from the clock edge.
        cmd(8'h20); cmd(8'h00); cmd(8'h05);
        @(posedge sys_clk);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_dt", {31'h0, data_transfer}, 32'h0);
        check("rst_mid_resp", {24'h0, response_byte}, 32'h0);
        check("rst_mid_state", {30'h0, state_dbg}, 32'h0);
        check("rst_mid_done", {31'h0, readout_done}, 32'h0);
        @(negedge sys_clk);
        #1 reset = 1'b1;
        @(negedge sys_clk);
        check("rst_no_done", {31'h0, readout_done}, 32'h0);
        cmd(8'h01);
        check("rst_status", {24'h0, response_byte}, 32'h00);

        // Randomized traffic checked against the model.
        for (int i = 0; i < 4000; i++) begin
            capture_busy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) drive(1'b0, 8'($urandom));
            else drive(1'b1, pick_byte());
        end
        drive(1'b0, 8'h00);
        @(negedge sys_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_command_decoder.md
SPI_COMMAND_DECODER -- requirements
Module: spi_command_decoder

Interface
REQ-001 Parameters: ACK_BYTE, 8'hA5, reply to an accepted command; ERR_BYTE, 8'hEE, reply to a rejected or unknown command.
REQ-002 Ports, one per line; sys_clk and reset first:
- sys_clk  in  1  system clock; one clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- command_byte  in  8  last byte received from the SPI driver.
- cmd_valid  in  1  one-cycle pulse, sys_clk domain; command_byte is valid in that cycle.
- capture_busy  in  1  camera capture module is writing a frame.
- response_byte  out  8  byte the SPI driver loads for the next transmission.
- data_transfer  out  1  readout active; the SPI driver sends pixel bytes instead of response_byte.
- capture_start  out  1  one-cycle pulse that starts a frame capture.
- readout_done  out  1  one-cycle pulse when a readout completes or aborts.
- state_dbg  out  2  current FSM state encoding (probe).

Function
REQ-003 Command codes: 8'h00 PADDING/NOP; 8'h01 STATUS; 8'h10 START_CAPTURE; 8'h20 START_READOUT; 8'h30 STOP_READOUT; all other codes are unknown.
REQ-004 FSM states and encodings: IDLE=0, LEN_HI=1, LEN_LO=2, READOUT=3; the FSM changes state only in a cycle where cmd_valid=1.
REQ-005 response_byte updates in the cycle after the cmd_valid pulse (latency 1) and holds until the next update.
REQ-006 IDLE, 8'h00: response_byte is 8'h00; state stays IDLE.
REQ-007 IDLE, 8'h01: response_byte is {6'b0, data_transfer, capture_busy}, sampled in the cmd_valid cycle.
REQ-008 IDLE, 8'h10 with capture_busy=0: capture_start pulses high for one cycle (latency 1), and response_byte is ACK_BYTE.
REQ-009 IDLE, 8'h10 with capture_busy=1: no capture_start pulse; response_byte is ERR_BYTE.
REQ-010 IDLE, 8'h20: response_byte is ACK_BYTE; state goes to LEN_HI.
REQ-011 IDLE, 8'h30 or an unknown code: response_byte is ERR_BYTE; state stays IDLE.
REQ-012 LEN_HI, any byte: the byte is stored as word_count[15:8]; response_byte is 8'h00; state goes to LEN_LO.
REQ-013 LEN_LO, any byte: the byte is stored as word_count[7:0]; the FSM computes the 17-bit byte_remaining = 2 × word_count.
REQ-014 LEN_LO with a nonzero result: data_transfer goes high next cycle, state goes to READOUT, response_byte is ACK_BYTE.
REQ-015 LEN_LO with word_count=0: response_byte is ERR_BYTE; state returns to IDLE; data_transfer stays low.
REQ-016 READOUT, each cmd_valid with any byte except 8'h30 decrements byte_remaining by 1; response_byte holds 8'h00.
REQ-017 READOUT, the decrement that reaches 0 drops data_transfer next cycle, pulses readout_done for one cycle, and returns the FSM to IDLE.
REQ-018 READOUT, 8'h30 (abort): data_transfer low next cycle, readout_done pulses, byte_remaining clears to 0, state goes to IDLE, response_byte is ACK_BYTE.
REQ-019 In READOUT, 8'h10 and 8'h20 are not decoded and are treated as padding bytes.
REQ-020 In READOUT, capture_start never asserts.
REQ-021 byte_remaining never wraps; a decrement at 0 is impossible by construction and is assertion-checked.
REQ-022 word_count 16'hFFFF gives byte_remaining 17'h1FFFE with no overflow.
REQ-023 cmd_valid asserted on consecutive cycles: each pulse is processed as a separate byte.
REQ-024 cmd_valid low: all outputs hold; capture_start and readout_done are low.

Reset
REQ-025 reset=0 asynchronously forces: state IDLE, response_byte 8'h00, data_transfer 0, capture_start 0, readout_done 0, word_count 0, byte_remaining 0.
REQ-026 Reset asserted during READOUT drops data_transfer immediately, with no readout_done pulse.
REQ-027 After reset deasserts, the first cmd_valid is decoded in IDLE.

Verification
REQ-028 Status check: reset, then cmd 8'h01 with capture_busy=1 -> response_byte 8'h01 one cycle later; data_transfer 0.
REQ-029 Capture start and busy: cmd 8'h10 with capture_busy=0 -> capture_start high exactly one cycle, response_byte 8'hA5; repeat with busy=1 -> no pulse, response_byte 8'hEE.
REQ-030 Full readout: cmds 8'h20, 8'h00, 8'h03 -> data_transfer rises after the third byte; then 6 × 8'h00 -> data_transfer falls after the 6th byte, readout_done one pulse, state_dbg 0.
REQ-031 Abort: cmds 8'h20, 8'h01, 8'h00 (256 words), 10 padding bytes, then 8'h30 -> data_transfer 0, readout_done pulse, response_byte 8'hA5.
REQ-032 Zero length: cmds 8'h20, 8'h00, 8'h00 -> response_byte 8'hEE; data_transfer never rises; state_dbg 0.
REQ-033 Reset mid-readout: reset pulsed low asynchronously in READOUT -> all outputs 0 within the same cycle; the next cmd 8'h01 returns 8'h00.
